// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment encodings (abcdefg, active-high),
// the invalid-digit code and the receive scanner's FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic {
    WAIT_STABLE = 1'b0,
    HOLD        = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_scan_to_bcd_if.sv
// Bus between a multiplexed segment source and the scan-to-BCD receiver.
// There is no ready: frame_valid is a one-cycle pulse and the consumer must
// take bcd_out/digit_err in that cycle; they then hold until the next frame.
interface seg7_scan_to_bcd_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic                    frame_valid;
  logic [NUM_DIGITS-1:0]   digit_err;
  scan_state_t             dbg_state;

  modport master (
    output seg_in, dig_sel,
    input  bcd_out, frame_valid, digit_err, dbg_state
  );

  modport slave (
    input  seg_in, dig_sel,
    output bcd_out, frame_valid, digit_err, dbg_state
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the BCD-to-7-segment encoder; anything that is
// not one of the ten digit glyphs decodes to BCD_INVALID with o_err set.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_nibble,
  output logic       o_err
);

  always_comb begin
    o_nibble = BCD_INVALID;
    o_err    = 1'b1;
    case (i_pattern)
      SEG_0: begin o_nibble = 4'd0; o_err = 1'b0; end
      SEG_1: begin o_nibble = 4'd1; o_err = 1'b0; end
      SEG_2: begin o_nibble = 4'd2; o_err = 1'b0; end
      SEG_3: begin o_nibble = 4'd3; o_err = 1'b0; end
      SEG_4: begin o_nibble = 4'd4; o_err = 1'b0; end
      SEG_5: begin o_nibble = 4'd5; o_err = 1'b0; end
      SEG_6: begin o_nibble = 4'd6; o_err = 1'b0; end
      SEG_7: begin o_nibble = 4'd7; o_err = 1'b0; end
      SEG_8: begin o_nibble = 4'd8; o_err = 1'b0; end
      SEG_9: begin o_nibble = 4'd9; o_err = 1'b0; end
      default: begin o_nibble = BCD_INVALID; o_err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_to_bcd.sv
// Recovers BCD digits from a multiplexed 7-segment bus: debounce each strobed
// digit, decode it into a shadow slot, publish a full frame with a pulse.
module seg7_scan_to_bcd
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_to_bcd_if.slave  bus
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [6:0]              r_seg_q;
  logic [NUM_DIGITS-1:0]   r_sel_q;
  logic [3:0]              r_cnt;
  scan_state_t             r_state;
  scan_state_t             w_next_state;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_err;
  logic [NUM_DIGITS-1:0]   r_captured;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_fv;

  logic                    w_new_onehot;
  logic                    w_change;
  logic                    w_capture;
  logic [NUM_DIGITS-1:0]   w_cap_mask;
  logic                    w_frame_done;
  logic [3:0]              w_nibble;
  logic                    w_err;

  // "New sample" is what the input registers load on this edge.
  assign w_new_onehot = (bus.dig_sel != '0) &&
                        ((bus.dig_sel & (bus.dig_sel - NUM_DIGITS'(1))) == '0);
  assign w_change     = {bus.dig_sel, bus.seg_in} != {r_sel_q, r_seg_q};
  assign w_frame_done = (r_captured == '1);
  assign w_cap_mask   = w_capture ? r_sel_q : '0;

  seg7_pattern_decode u_decode (
    .i_pattern (r_seg_q),
    .o_nibble  (w_nibble),
    .o_err     (w_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_q <= '0;
      r_sel_q <= '0;
      r_cnt   <= '0;
    end else begin
      r_seg_q <= bus.seg_in;
      r_sel_q <= bus.dig_sel;
      if (!w_new_onehot)
        r_cnt <= '0;
      else if (w_change)
        r_cnt <= 4'd1;
      else if (r_cnt != STABLE)
        r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_STABLE;
    else     r_state <= w_next_state;
  end

  // The value must still be on the bus at the capture edge, so a strobe of
  // only STABLE_CYCLES clocks is rejected and the minimum width is one more.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      WAIT_STABLE: begin
        if (r_cnt == STABLE && !w_change) begin
          w_capture    = 1'b1;
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (w_change) w_next_state = WAIT_STABLE;
      end
      default: w_next_state = WAIT_STABLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_shadow_err <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_cap_mask[i]) begin
          r_shadow[4*i +: 4] <= w_nibble;
          r_shadow_err[i]    <= w_err;
        end
      end
    end
  end

  // A capture on the publishing edge starts the next frame's mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_captured <= '0;
      r_bcd      <= '0;
      r_err      <= '0;
      r_fv       <= 1'b0;
    end else begin
      r_fv <= w_frame_done;
      if (w_frame_done) begin
        r_bcd      <= r_shadow;
        r_err      <= r_shadow_err;
        r_captured <= w_cap_mask;
      end else begin
        r_captured <= r_captured | w_cap_mask;
      end
    end
  end

  assign bus.bcd_out     = r_bcd;
  assign bus.digit_err   = r_err;
  assign bus.frame_valid = r_fv;
  assign bus.dbg_state   = r_state;

endmodule

// File: doc/seg7_scan_to_bcd.md
# seg7_scan_to_bcd

Receive-side block for multiplexed 7-segment display buses: it watches a time-multiplexed segment bus (segment lines plus one-hot digit strobes, as driven by our BCD-to-7-segment display path) and recovers the BCD digits. Each strobed digit is debounced for a programmable number of cycles and then decoded back to a 4-bit code. A complete frame of decoded digits is published with a one-cycle valid pulse. The block is used for loopback self-check of display drivers and for reading external multiplexed displays.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, 1..8.
- STABLE_CYCLES, 3: consecutive sampling edges a strobe/segment value must hold before it is captured, 1..15.

- clk  in  1  sole clock; all flops on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_sel  in  NUM_DIGITS  digit strobe, active-high, must be one-hot to be accepted; bit i selects digit i.
- bcd_out  out  4*NUM_DIGITS  last complete frame; nibble i (bits 4i+3:4i) is digit i.
- frame_valid  out  1  one-cycle pulse when bcd_out is updated.
- digit_err  out  NUM_DIGITS  bit i set if digit i of the last frame was not a legal pattern; updated with bcd_out.

## Operation
- Reset: bcd_out=0, frame_valid=0, digit_err=0, captured mask=0, stability counter=0, input sample registers=0, FSM=WAIT_STABLE.
- Input stage: seg_in and dig_sel are registered every cycle (seg_q, sel_q). The stability counter compares the new sample with the previous one:
  - If the value is unchanged and sel_q is one-hot, the counter increments, saturating at STABLE_CYCLES.
  - If the value changed, the counter loads 1 when the new sel_q is one-hot and 0 otherwise.
  - If sel_q is all-zero or multi-hot, the counter is held at 0 and nothing is captured.
- FSM:
  - WAIT_STABLE -> HOLD when the counter reaches STABLE_CYCLES. On that transition the decoded nibble and error bit are written into shadow slot i (i = index of sel_q) and captured[i] is set.
  - HOLD -> WAIT_STABLE on any change in {sel_q, seg_q}. This prevents a held digit from being captured twice.
- Decode table (seg_in abcdefg -> nibble):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - Any other pattern, including all-off, decodes to 4'hF with its error bit set.
- Recapture: if a digit is captured again before the frame completes, its shadow slot is overwritten with the newer value.
- Frame completion: when captured becomes all-ones, on the next edge shadow->bcd_out, shadow errors->digit_err, frame_valid=1 for exactly one cycle, and captured is cleared.
  - Clearing takes priority over any capture on the same edge, except the completing capture itself. A capture on the clearing edge sets its bit in the fresh mask.
- Reset mid-frame: the partial frame is discarded; bcd_out and digit_err return to 0.

## Timing
- Let the value on seg_in/dig_sel be present at input edges E1..En.
  - seg_q/sel_q show it after E1; the counter is 1 after E1.
  - The counter reaches STABLE_CYCLES after E(STABLE_CYCLES).
  - The shadow write and HOLD entry happen at E(STABLE_CYCLES+1).
- Minimum strobe width for capture: STABLE_CYCLES+1 clocks.
- Latency from the completing capture edge to bcd_out/frame_valid update: 1 clock.
- frame_valid is high for one cycle per frame and is never high in consecutive cycles for NUM_DIGITS>1.
- No backpressure: consumers must sample during the frame_valid cycle. bcd_out holds its value until the next frame.

## Structure
- Package seg7_pkg, shared with the display driver:
  - SEG_0..SEG_9 7-bit constants in abcdefg order.
  - BCD_INVALID = 4'hF.
  - The FSM state enum (WAIT_STABLE, HOLD).
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern -> {err, nibble}; one instance.
- Top module: input registers, stability counter, FSM, shadow registers, captured mask, output registers.

## Test plan
All scenarios use NUM_DIGITS=4 and STABLE_CYCLES=3.
- Reset: assert rst asynchronously between edges -> bcd_out=16'h0000, frame_valid=0, digit_err=4'b0000 immediately.
- Frame capture: strobe dig_sel=0001/0010/0100/1000 for 5 cycles each with patterns for 1,2,3,4 -> one frame_valid pulse, bcd_out=16'h4321, digit_err=0.
- Short strobe: digit 0 held for 3 cycles (below the minimum of 4), digits 1..3 valid -> no frame_valid. Then hold digit 0 for 5 cycles -> frame_valid, nibble 0 correct.
- Illegal pattern: 0000001 on digit 2 within an otherwise valid frame -> bcd_out[11:8]=4'hF, digit_err=4'b0100.
- Bad strobe: dig_sel=0011 or 0000 held for 10 cycles -> no capture; the mask is unchanged (verified by a later frame needing all 4 digits).
- Reset mid-frame: digits 0..2 captured, pulse rst, then send only digit 3 -> no frame_valid until digits 0..2 are resent.
